aibnd_sync_filt: RTL and testbench
==================================

# aibnd_sync_filt

Digital deglitch filter and edge-event capture stage that sits directly downstream of the AIB two-stage scan synchronizer. It consumes the synchronized level (`q` of the synchronizer) and requires that level to be stable for a programmable number of cycles before accepting it. Each accepted transition produces a one-cycle rise or fall pulse, increments a saturating event counter, and is posted to a valid/ack event register with sticky overflow reporting. All logic is in the same clock domain as the synchronizer.

## Interface

Parameters:
- `FILT_CYC`, 4: consecutive sampled cycles a new level must hold before acceptance; legal range 1..255.
- `CNT_W`, 8: width of `evt_cnt`; legal range 2..16.
- `RST_VAL`, 1'b0: reset value of `lvl_out`.

Ports:
- `clk`  input  1  block clock; same clock as the upstream synchronizer.
- `rb`  input  1  reset; synchronous, active-low.
- `sync_in`  input  1  synchronized level from the synchronizer output.
- `filt_en`  input  1  1 = filter active; 0 = bypass, which behaves exactly as `FILT_CYC`=1.
- `cnt_clr`  input  1  clears `evt_cnt` and `evt_ovf`.
- `evt_ack`  input  1  consumer acknowledges the pending event.
- `lvl_out`  output  1  filtered level.
- `rise_pls`  output  1  one-cycle pulse on an accepted 0->1 transition.
- `fall_pls`  output  1  one-cycle pulse on an accepted 1->0 transition.
- `evt_vld`  output  1  an event is pending.
- `evt_edge`  output  1  direction of the pending event: 1 = rise, 0 = fall.
- `evt_ovf`  output  1  sticky flag: an event was dropped.
- `evt_cnt`  output  `CNT_W`  saturating count of accepted transitions.

## Operation

- Internal state: `stab_cnt` is an 8-bit stability counter.
- Reset, applied at a `clk` edge with `rb`=0: `lvl_out`=`RST_VAL`; `stab_cnt`, `rise_pls`, `fall_pls`, `evt_vld`, `evt_edge`, `evt_ovf` and `evt_cnt` all = 0. Reset overrides every other input.
- Filter, evaluated each edge with `rb`=1. Let `thr` = `FILT_CYC`-1 when `filt_en`=1, else 0.
  - `sync_in`==`lvl_out`: `stab_cnt`<=0. Any partial count is discarded, so a glitch shorter than `FILT_CYC` cycles never propagates.
  - `sync_in`!=`lvl_out` and `stab_cnt`<`thr`: `stab_cnt`<=`stab_cnt`+1.
  - `sync_in`!=`lvl_out` and `stab_cnt`>=`thr`: this is an accepted flip. `lvl_out`<=`sync_in` and `stab_cnt`<=0.
  - Clearing `filt_en` mid-count makes the next differing sample an immediate flip.
- Pulses: `rise_pls`/`fall_pls` are registered. They are 1 only in the cycle after the flip edge and coincide with the new `lvl_out`.
- Event register, on a flip:
  - If `evt_vld`=0, or `evt_ack`=1 in the same cycle: `evt_vld`<=1 and `evt_edge`<=new level.
  - If `evt_vld`=1 and `evt_ack`=0: the new event is dropped, `evt_ovf`<=1, and `evt_edge` keeps the older event.
- Event register, no flip: `evt_ack`=1 with `evt_vld`=1 gives `evt_vld`<=0. `evt_ack` while `evt_vld`=0 is ignored.
- Counter:
  - A flip increments `evt_cnt`; it saturates at 2^`CNT_W`-1 and never wraps.
  - `cnt_clr` with no flip: `evt_cnt`<=0.
  - `cnt_clr` together with a flip: `evt_cnt`<=1.
  - `evt_ovf` next value = (`evt_ovf` & ~`cnt_clr`) | dropped-event-this-cycle. A drop in the same cycle as a clear therefore leaves `evt_ovf`=1.
  - `cnt_clr` does not affect `evt_vld` or `evt_edge`.
- Reset release: the block generates no edge at release. If `sync_in`!=`RST_VAL`, filtering starts on the first edge with `rb`=1.

## Timing

- Acceptance latency: `sync_in` first differs at sampling edge k and stays stable, so the flip occurs at edge k+`FILT_CYC`-1. `lvl_out`, the pulse and `evt_vld` are visible after that edge.
- Total latency from the asynchronous pad is the synchronizer depth plus `FILT_CYC` cycles.
- Minimum spacing of accepted flips is `FILT_CYC` cycles; with bypass, back-to-back flips every cycle are legal.
- Handshake: an event is consumed on any edge where `evt_vld`=1 and `evt_ack`=1. `evt_ack` needs no return-to-zero and may be held high.
- Every output is a flop output; there are no combinational input-to-output paths.

## Test plan

- Reset and glitch, `FILT_CYC`=4, `RST_VAL`=0. Drive `sync_in`=1 for 3 cycles, then 0: `lvl_out` stays 0, no pulse, `evt_cnt`=0. Then drive 1 held: `rise_pls` and `lvl_out`=1 appear after the 4th sampling edge, `evt_vld`=1, `evt_edge`=1, `evt_cnt`=1.
- Bypass: `filt_en`=0 and toggle `sync_in` every cycle for 10 cycles with `evt_ack`=1 held. Expect `lvl_out` to follow `sync_in` one cycle later, rise and fall pulses to alternate, `evt_cnt`=10 and `evt_ovf`=0.
- Overflow: with `evt_ack`=0, cause a rise then a fall. Expect `evt_vld`=1, `evt_edge`=1 (the first event kept), `evt_ovf`=1 and `evt_cnt`=2. Then assert `cnt_clr`: `evt_cnt`=0, `evt_ovf`=0, `evt_vld` still 1.
- Simultaneous events:
  - A flip in the same cycle as `evt_ack`: `evt_vld` stays 1, `evt_edge` takes the new direction, `evt_ovf`=0.
  - A flip in the same cycle as `cnt_clr`: `evt_cnt`=1.
- Saturation, `CNT_W`=2: 5 accepted flips give `evt_cnt`=3 with no wrap.
- Reset mid-operation: drop `rb` while `stab_cnt`=2 and `evt_vld`=1. One edge later all outputs are at their reset values. After release with `sync_in`=1 held, the next rise is accepted a full `FILT_CYC` cycles later.

Source files
------------

// File: rtl/aibnd_sync_filt_if.sv
// Event/level bus between the deglitch filter and its consumer.
// The master side drives the synchronized level and controls and receives the filtered results.
interface aibnd_sync_filt_if #(
  parameter int unsigned CNT_W = 8
);
  logic             sync_in;
  logic             filt_en;
  logic             cnt_clr;
  logic             evt_ack;
  logic             lvl_out;
  logic             rise_pls;
  logic             fall_pls;
  logic             evt_vld;
  logic             evt_edge;
  logic             evt_ovf;
  logic [CNT_W-1:0] evt_cnt;

  modport master (
    output sync_in, filt_en, cnt_clr, evt_ack,
    input  lvl_out, rise_pls, fall_pls, evt_vld, evt_edge, evt_ovf, evt_cnt
  );

  modport slave (
    input  sync_in, filt_en, cnt_clr, evt_ack,
    output lvl_out, rise_pls, fall_pls, evt_vld, evt_edge, evt_ovf, evt_cnt
  );
endinterface

// File: rtl/aibnd_sync_filt.sv
// Deglitch filter and edge-event capture stage for the AIB scan synchronizer output.
// A new level must hold for FILT_CYC samples before it is accepted; each accepted flip
// produces a pulse, bumps a saturating counter and is posted to a valid/ack event register.
module aibnd_sync_filt #(
  parameter int unsigned FILT_CYC = 4,
  parameter int unsigned CNT_W    = 8,
  parameter logic        RST_VAL  = 1'b0
) (
  input  logic             clk,
  input  logic             rb,
  aibnd_sync_filt_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [7:0]       ThrFilt = 8'(FILT_CYC - 1);

  logic             lvl_q,  lvl_d;
  logic [7:0]       stab_q, stab_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             vld_q,  vld_d;
  logic             edge_q, edge_d;
  logic             ovf_q,  ovf_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic [7:0]       thr;
  logic             differs;
  logic             flip;
  logic             drop;
  logic [CNT_W-1:0] cnt_base;

  // Stability threshold; bypass is equivalent to a one-sample filter.
  always_comb begin
    thr     = bus.filt_en ? ThrFilt : 8'd0;
    differs = (bus.sync_in != lvl_q);
    flip    = differs && (stab_q >= thr);
    drop    = flip && vld_q && !bus.evt_ack;
  end

  // Filter next state: any sample matching the current level discards a partial count.
  always_comb begin
    lvl_d  = lvl_q;
    stab_d = 8'd0;
    if (flip) begin
      lvl_d  = bus.sync_in;
      stab_d = 8'd0;
    end else if (differs) begin
      stab_d = stab_q + 8'd1;
    end
  end

  // Registered edge pulses, aligned with the new filtered level.
  always_comb begin
    rise_d = flip && bus.sync_in;
    fall_d = flip && !bus.sync_in;
  end

  // Event register: an unacknowledged pending event wins over a new one.
  always_comb begin
    vld_d  = vld_q;
    edge_d = edge_q;
    if (flip) begin
      if (!vld_q || bus.evt_ack) begin
        vld_d  = 1'b1;
        edge_d = bus.sync_in;
      end
    end else if (vld_q && bus.evt_ack) begin
      vld_d = 1'b0;
    end
  end

  // Saturating event counter; a clear coinciding with a flip leaves a count of one.
  always_comb begin
    cnt_base = bus.cnt_clr ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (flip && (cnt_base != CntMax)) begin
      cnt_d = cnt_base + 1'b1;
    end
    ovf_d = (ovf_q && !bus.cnt_clr) || drop;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rb) begin
      lvl_q  <= RST_VAL;
      stab_q <= 8'd0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      vld_q  <= 1'b0;
      edge_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lvl_q  <= lvl_d;
      stab_q <= stab_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      vld_q  <= vld_d;
      edge_q <= edge_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  // Every output is a flop output.
  assign bus.lvl_out  = lvl_q;
  assign bus.rise_pls = rise_q;
  assign bus.fall_pls = fall_q;
  assign bus.evt_vld  = vld_q;
  assign bus.evt_edge = edge_q;
  assign bus.evt_ovf  = ovf_q;
  assign bus.evt_cnt  = cnt_q;

endmodule

// File: tb/tb_aibnd_sync_filt.sv
// Directed bench for aibnd_sync_filt: a FILT_CYC=4/CNT_W=8 instance carries the main
// scenarios and a CNT_W=2 instance shares its stimulus for the saturation case.
module tb_aibnd_sync_filt;

  logic clk = 1'b0;
  logic rb;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  aibnd_sync_filt_if #(.CNT_W(8)) bus ();
  aibnd_sync_filt_if #(.CNT_W(2)) bus2 ();

  assign bus2.sync_in = bus.sync_in;
  assign bus2.filt_en = bus.filt_en;
  assign bus2.cnt_clr = bus.cnt_clr;
  assign bus2.evt_ack = bus.evt_ack;

  aibnd_sync_filt #(.FILT_CYC(4), .CNT_W(8), .RST_VAL(1'b0)) dut (
    .clk (clk),
    .rb  (rb),
    .bus (bus)
  );

  aibnd_sync_filt #(.FILT_CYC(4), .CNT_W(2), .RST_VAL(1'b0)) dut_sat (
    .clk (clk),
    .rb  (rb),
    .bus (bus2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle so outputs are read away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic lvl, input logic rise, input logic fall,
                           input logic vld, input logic edg, input logic ovf,
                           input logic [7:0] cnt);
    check_eq({tag, ".lvl"},  {31'd0, bus.lvl_out},  {31'd0, lvl});
    check_eq({tag, ".rise"}, {31'd0, bus.rise_pls}, {31'd0, rise});
    check_eq({tag, ".fall"}, {31'd0, bus.fall_pls}, {31'd0, fall});
    check_eq({tag, ".vld"},  {31'd0, bus.evt_vld},  {31'd0, vld});
    check_eq({tag, ".edge"}, {31'd0, bus.evt_edge}, {31'd0, edg});
    check_eq({tag, ".ovf"},  {31'd0, bus.evt_ovf},  {31'd0, ovf});
    check_eq({tag, ".cnt"},  {24'd0, bus.evt_cnt},  {24'd0, cnt});
  endtask

  initial begin
    rb          = 1'b0;
    bus.sync_in = 1'b0;
    bus.filt_en = 1'b1;
    bus.cnt_clr = 1'b0;
    bus.evt_ack = 1'b0;
    step();
    step();
    check_all("reset", 0, 0, 0, 0, 0, 0, 8'd0);
    check_eq("reset.sat_cnt", {30'd0, bus2.evt_cnt}, 32'd0);

    // 3-cycle glitch must be swallowed.
    rb          = 1'b1;
    bus.sync_in = 1'b1;
    repeat (3) step();
    check_eq("glitch.lvl_hold", {31'd0, bus.lvl_out}, 32'd0);
    bus.sync_in = 1'b0;
    step();
    check_all("glitch", 0, 0, 0, 0, 0, 0, 8'd0);

    // Held level is accepted on the 4th sampling edge.
    bus.sync_in = 1'b1;
    repeat (3) step();
    check_eq("accept.lvl_early", {31'd0, bus.lvl_out}, 32'd0);
    step();
    check_all("accept", 1, 1, 0, 1, 1, 0, 8'd1);
    step();
    check_eq("accept.rise_one_cyc", {31'd0, bus.rise_pls}, 32'd0);

    // Ack consumes the event.
    bus.evt_ack = 1'b1;
    step();
    check_eq("ack.vld", {31'd0, bus.evt_vld}, 32'd0);

    // Bypass with ack held: toggle every cycle.
    bus.cnt_clr = 1'b1;
    step();
    check_eq("clr.cnt", {24'd0, bus.evt_cnt}, 32'd0);
    bus.cnt_clr = 1'b0;
    bus.filt_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.sync_in = (i % 2 == 1);
      step();
      check_eq($sformatf("byp%0d.lvl", i),  {31'd0, bus.lvl_out},  {31'd0, (i % 2 == 1)});
      check_eq($sformatf("byp%0d.rise", i), {31'd0, bus.rise_pls}, {31'd0, (i % 2 == 1)});
      check_eq($sformatf("byp%0d.fall", i), {31'd0, bus.fall_pls}, {31'd0, (i % 2 == 0)});
    end
    check_all("bypass", 1, 1, 0, 1, 1, 0, 8'd10);

    // Overflow: fall posted, following rise dropped.
    step();
    check_eq("ovf.pre_vld", {31'd0, bus.evt_vld}, 32'd0);
    bus.evt_ack = 1'b0;
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    bus.sync_in = 1'b0;
    step();
    check_all("ovf.fall", 0, 0, 1, 1, 0, 0, 8'd1);
    bus.sync_in = 1'b1;
    step();
    check_all("ovf.drop", 1, 1, 0, 1, 0, 1, 8'd2);
    bus.cnt_clr = 1'b1;
    step();
    check_all("ovf.clr", 1, 0, 0, 1, 0, 0, 8'd0);
    bus.cnt_clr = 1'b0;

    // Flip coinciding with ack replaces the pending event.
    bus.evt_ack = 1'b1;
    step();
    bus.evt_ack = 1'b0;
    bus.sync_in = 1'b0;
    step();
    check_all("simack.fall", 0, 0, 1, 1, 0, 0, 8'd1);
    bus.evt_ack = 1'b1;
    bus.sync_in = 1'b1;
    step();
    check_all("simack.rise", 1, 1, 0, 1, 1, 0, 8'd2);

    // Flip with clear, and a drop in that same cycle keeps ovf set.
    bus.evt_ack = 1'b0;
    bus.cnt_clr = 1'b1;
    bus.sync_in = 1'b0;
    step();
    check_all("simclr", 0, 0, 1, 1, 1, 1, 8'd1);
    bus.cnt_clr = 1'b0;

    // Ack without flip clears valid; ack with nothing pending is ignored.
    bus.evt_ack = 1'b1;
    step();
    check_eq("ack2.vld", {31'd0, bus.evt_vld}, 32'd0);
    step();
    check_eq("ack_idle.vld", {31'd0, bus.evt_vld}, 32'd0);
    bus.evt_ack = 1'b0;

    // Saturation: 5 flips, narrow counter stops at 3.
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sync_in = (i % 2 == 0);
      step();
      check_eq($sformatf("sat%0d.cnt2", i), {30'd0, bus2.evt_cnt}, (i < 3) ? i + 1 : 3);
    end
    check_eq("sat.cnt8", {24'd0, bus.evt_cnt}, 32'd5);

    // Reset mid-count with an event pending.
    bus.filt_en = 1'b1;
    bus.sync_in = 1'b0;
    step();
    step();
    check_eq("midrst.pre_vld", {31'd0, bus.evt_vld}, 32'd1);
    check_eq("midrst.pre_lvl", {31'd0, bus.lvl_out}, 32'd1);
    rb = 1'b0;
    step();
    check_all("midrst", 0, 0, 0, 0, 0, 0, 8'd0);
    check_eq("midrst.sat_cnt", {30'd0, bus2.evt_cnt}, 32'd0);
    bus.sync_in = 1'b1;
    rb          = 1'b1;
    repeat (3) step();
    check_eq("release.lvl_early", {31'd0, bus.lvl_out}, 32'd0);
    step();
    check_all("release", 1, 1, 0, 1, 1, 0, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
